// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-adder cell with a registered carry adds two
// WIDTH-bit operands LSB first, one bit per clock, then pulses done.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s, co, last;

  // The full-adder cell; acc keeps only the WIDTH-1 bits still needed, so the
  // last sum bit plus acc forms the complete result.
  assign s       = a_sh[0] ^ b_sh[0] ^ carry;
  assign co      = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
  assign acc_nxt = {s, acc};
  assign last    = (cnt == CW'(WIDTH - 1));

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_nxt[WIDTH-1:1];
          carry <= co;
          // cnt stops at WIDTH-1 so it never wraps for power-of-two widths
          if (last) begin
            sum  <= acc_nxt;
            cout <= co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit: an arithmetic cycle model checked
// every cycle on an 8-bit and a 4-bit instance, plus directed literal checks.
module tb_serial_add_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       ready, busy, done, cout;
  logic [7:0] sum;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] sum4;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .sum(sum), .cout(cout), .done(done)
  );

  serial_add_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .sum(sum4), .cout(cout4), .done(done4)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: an accepted add is busy for WIDTH+1 cycles, the result a+b+cin
  // appears with done in the last of them, and ready returns the cycle after.
  logic       m8_busy = 1'b0, m4_busy = 1'b0;
  int         m8_phase = 0, m4_phase = 0;
  logic [8:0] m8_res;
  logic [4:0] m4_res;
  logic [7:0] m8_sum = '0;
  logic [3:0] m4_sum = '0;
  logic       m8_cout = 1'b0, m4_cout = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_busy = 1'b0; m8_phase = 0; m8_sum = '0; m8_cout = 1'b0;
    end else if (!m8_busy) begin
      if (start) begin
        m8_busy  = 1'b1;
        m8_phase = 1;
        m8_res   = {1'b0, a} + {1'b0, b} + 9'(cin);
      end
    end else begin
      m8_phase++;
      if (m8_phase == 9)  {m8_cout, m8_sum} = m8_res;
      if (m8_phase == 10) m8_busy = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m4_busy = 1'b0; m4_phase = 0; m4_sum = '0; m4_cout = 1'b0;
    end else if (!m4_busy) begin
      if (start4) begin
        m4_busy  = 1'b1;
        m4_phase = 1;
        m4_res   = {1'b0, a4} + {1'b0, b4} + 5'(cin4);
      end
    end else begin
      m4_phase++;
      if (m4_phase == 5) {m4_cout, m4_sum} = m4_res;
      if (m4_phase == 6) m4_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("cyc8_reset", {ready, busy, done, cout, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      chk("cyc4_reset", {ready4, busy4, done4, cout4, sum4}, {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    end else begin
      chk("cyc8", {ready, busy, done, cout, sum},
          {!m8_busy, m8_busy, m8_busy && (m8_phase == 9), m8_cout, m8_sum});
      chk("cyc4", {ready4, busy4, done4, cout4, sum4},
          {!m4_busy, m4_busy, m4_busy && (m4_phase == 5), m4_cout, m4_sum});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic icin);
    a = ia; b = ib; cin = icin; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act, exp);
  endtask

  // Returns the cycle index (relative to the accept cycle) at which done is seen.
  task automatic waitDone(input int first, output int n);
    n = first;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) checkOutput("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int nd;
    int dc[3];
    logic saw_done;
    logic hold_ok;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) tick();
    checkOutput("reset_state", {ready, busy, done, cout, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    tick();

    // Basic add and latency
    applyStimulus(8'h3C, 8'h0F, 1'b0);
    waitDone(1, n);
    checkOutput("t1_done_cycle", 64'(n), 64'd9);
    checkOutput("t1_sum", {cout, sum}, {1'b0, 8'h4B});
    checkOutput("t1_busy_at_done", busy, 1'b1);
    tick();
    checkOutput("t1_ready_back", ready, 1'b1);

    // Carry boundaries
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(1, n);
    checkOutput("t2_ff_plus_1", {cout, sum}, {1'b1, 8'h00});
    tick();
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    waitDone(1, n);
    checkOutput("t2_saturated", {cout, sum}, {1'b1, 8'hFF});
    tick();
    applyStimulus(8'h00, 8'h00, 1'b1);
    waitDone(1, n);
    checkOutput("t2_cin_only", {cout, sum}, {1'b0, 8'h01});
    tick();

    // Start while busy is lost
    applyStimulus(8'h01, 8'h01, 1'b0);
    repeat (3) tick();
    a = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(5, n);
    checkOutput("t3_done_cycle", 64'(n), 64'd9);
    checkOutput("t3_sum", sum, 8'h02);
    saw_done = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (sum !== 8'h02) hold_ok = 1'b0;
    end
    checkOutput("t3_no_second_done", saw_done, 1'b0);
    checkOutput("t3_sum_hold", hold_ok, 1'b1);

    // start held high: back-to-back adds
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 30) start = 1'b0;
      if (done && nd < 3) begin
        dc[nd] = c;
        nd++;
      end
    end
    checkOutput("t4_done_count", 64'(nd), 64'd3);
    checkOutput("t4_done0", 64'(dc[0]), 64'd9);
    checkOutput("t4_done1", 64'(dc[1]), 64'd19);
    checkOutput("t4_done2", 64'(dc[2]), 64'd29);
    checkOutput("t4_sum", {cout, sum}, {1'b0, 8'h30});
    tick();

    // Reset mid-add aborts it
    applyStimulus(8'h3C, 8'h0F, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    checkOutput("t5_after_abort", {ready, done, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checkOutput("t5_no_done", saw_done, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone(1, n);
    checkOutput("t5_done_cycle", 64'(n), 64'd9);
    checkOutput("t5_sum", {cout, sum}, {1'b0, 8'h02});
    tick();

    // Exhaustive 4-bit
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          n = 1;
          while (!done4 && n < 20) begin
            tick();
            n++;
          end
          checkOutput("t6_add", {cout4, sum4}, 64'(ai + bi + ci));
          tick();
        end
      end
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
